// File: rtl/cfg_seq_pkg.sv
// Shared section codes, FSM state encoding and section-decode helper for config_sequencer.
// The CHK state exists only when CFG_SEQ_CHECKSUM_EN is defined.
package cfg_seq_pkg;

    localparam logic [15:0] CONFIG_SB   = 16'd7;
    localparam logic [15:0] CONFIG_CB0  = 16'd6;
    localparam logic [15:0] CONFIG_CB1  = 16'd5;
    localparam logic [15:0] CONFIG_CLB  = 16'd4;
    localparam logic [15:0] CONFIG_IDLE = 16'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
`ifdef CFG_SEQ_CHECKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_FIN   = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    function automatic logic is_cfg_section(input logic [15:0] section);
        return (section == CONFIG_SB)  || (section == CONFIG_CB0) ||
               (section == CONFIG_CB1) || (section == CONFIG_CLB);
    endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// Bitstream input, tile configuration write bus and status for config_sequencer.
// master = stream source / observer, slave = the sequencer.
interface config_sequencer_if;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] write_count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, config_addr, config_data, busy, done, error, write_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, config_addr, config_data, busy, done, error, write_count
    );
endinterface

// File: rtl/cfg_checksum.sv
// 32-bit wrapping running sum with synchronous clear; only built with CFG_SEQ_CHECKSUM_EN.
module cfg_checksum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        add_en,
    input  logic [31:0] add_val,
    output logic [31:0] sum
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= 32'd0;
        end else if (add_en) begin
            sum <= sum + add_val;
        end
    end
endmodule

// File: rtl/config_sequencer.sv
// Bitstream loader: header N, N (address, data) pairs, optional checksum trailer (CFG_SEQ_CHECKSUM_EN).
// Each accepted data word becomes a one-cycle registered tile write on the following cycle.
module config_sequencer
    import cfg_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    config_sequencer_if.slave   bus
);

    state_t      state, state_n;
    logic        word_rdy, acc, go;
    logic [15:0] remaining;
    logic [31:0] addr_q;
    logic [31:0] cfg_addr_q, cfg_data_q;
    logic [15:0] wr_cnt;
    logic        busy_c, done_c, error_c;

    assign acc = bus.in_valid && word_rdy;
    assign go  = bus.start && ((state == ST_IDLE) || (state == ST_ERROR));

`ifdef CFG_SEQ_CHECKSUM_EN
    logic [31:0] sum;

    cfg_checksum u_checksum (
        .clk     (clk),
        .reset   (reset),
        .clear   (go),
        .add_en  (acc && ((state == ST_ADDR) || (state == ST_DATA))),
        .add_val (bus.in_data),
        .sum     (sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (bus.start) state_n = ST_HDR;
            end
            ST_HDR: begin
                if (acc) begin
`ifdef CFG_SEQ_CHECKSUM_EN
                    state_n = (bus.in_data[15:0] == 16'd0) ? ST_CHK : ST_ADDR;
`else
                    state_n = (bus.in_data[15:0] == 16'd0) ? ST_FIN : ST_ADDR;
`endif
                end
            end
            ST_ADDR: begin
                if (acc) state_n = is_cfg_section(bus.in_data[31:16]) ? ST_DATA : ST_ERROR;
            end
            ST_DATA: begin
                if (acc) begin
`ifdef CFG_SEQ_CHECKSUM_EN
                    state_n = (remaining == 16'd1) ? ST_CHK : ST_ADDR;
`else
                    state_n = (remaining == 16'd1) ? ST_FIN : ST_ADDR;
`endif
                end
            end
`ifdef CFG_SEQ_CHECKSUM_EN
            ST_CHK: begin
                if (acc) state_n = (bus.in_data == sum) ? ST_FIN : ST_ERROR;
            end
`endif
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        word_rdy = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        error_c  = 1'b0;
        case (state)
            ST_HDR, ST_ADDR, ST_DATA: begin
                word_rdy = 1'b1;
                busy_c   = 1'b1;
            end
`ifdef CFG_SEQ_CHECKSUM_EN
            ST_CHK: begin
                word_rdy = 1'b1;
                busy_c   = 1'b1;
            end
`endif
            ST_FIN:   done_c  = 1'b1;
            ST_ERROR: error_c = 1'b1;
            default: ;
        endcase
    end

    // Write bus returns to section 0 (no tile selected) on every cycle without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining  <= 16'd0;
            addr_q     <= 32'd0;
            cfg_addr_q <= 32'd0;
            cfg_data_q <= 32'd0;
            wr_cnt     <= 16'd0;
        end else begin
            cfg_addr_q <= 32'd0;
            cfg_data_q <= 32'd0;
            if (go) wr_cnt <= 16'd0;
            if (acc) begin
                case (state)
                    ST_HDR: remaining <= bus.in_data[15:0];
                    ST_ADDR: begin
                        if (is_cfg_section(bus.in_data[31:16])) addr_q <= bus.in_data;
                    end
                    ST_DATA: begin
                        cfg_addr_q <= addr_q;
                        cfg_data_q <= bus.in_data;
                        remaining  <= remaining - 16'd1;
                        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready    = word_rdy;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.error       = error_c;
    assign bus.config_addr = cfg_addr_q;
    assign bus.config_data = cfg_data_q;
    assign bus.write_count = wr_cnt;

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer; trailer words are sent only when CFG_SEQ_CHECKSUM_EN is defined.
module tb_config_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    config_sequencer_if bus();

    config_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_c[$];
    int          cyc      = 0;
    int          done_cnt = 0;
    int          idle_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (bus.config_addr != 32'd0) begin
            wr_a.push_back(bus.config_addr);
            wr_d.push_back(bus.config_data);
            wr_c.push_back(cyc);
        end else if (bus.config_data != 32'd0) begin
            idle_bad++;
        end
        if (bus.done) done_cnt++;
    end

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        wr_c.delete();
        done_cnt = 0;
        idle_bad = 0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        sync();
        bus.start = 1'b1;
        sync();
        bus.start = 1'b0;
    endtask

    // Call aligned to 1ns after a rising edge; returns aligned the same way.
    task automatic send(input logic [31:0] w);
        int   budget = 20;
        logic ok     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                sync();
            end else begin
                budget--;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input int exp);
        int budget = 30;
        while (done_cnt < exp && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("done_wait", done_cnt, exp);
    endtask

    logic [31:0] sum;
    logic [31:0] ea[3];
    logic [31:0] ed[3];

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_done",     {31'd0, bus.done},     32'd0);
        check("rst_error",    {31'd0, bus.error},    32'd0);
        check("rst_wcount",   {16'd0, bus.write_count}, 32'd0);
        check("rst_addr",     bus.config_addr, 32'd0);
        check("rst_data",     bus.config_data, 32'd0);

        // Single pair
        sync();
        clear_log();
        pulse_start();
        send(32'd1);
        send(32'h0007_0003);
        send(32'h0000_0005);
`ifdef CFG_SEQ_CHECKSUM_EN
        send(32'h0007_0008);
`endif
        wait_done(1);
        check("one_nwr",  wr_a.size(), 32'd1);
        if (wr_a.size() == 1) begin
            check("one_addr", wr_a[0], 32'h0007_0003);
            check("one_data", wr_d[0], 32'h0000_0005);
        end
        @(negedge clk);
        check("one_wcount", {16'd0, bus.write_count}, 32'd1);
        check("one_busy",   {31'd0, bus.busy}, 32'd0);

        // Three back-to-back pairs, one per section
        sync();
        clear_log();
        pulse_start();
        sum = 32'd0;
        send(32'd3);
        for (int i = 0; i < 3; i++) begin
            ea[i] = {16'(4 + i), 16'(i + 1)};
            ed[i] = 32'h11 * (i + 1);
            send(ea[i]);
            send(ed[i]);
            sum = sum + ea[i] + ed[i];
        end
`ifdef CFG_SEQ_CHECKSUM_EN
        send(sum);
`endif
        wait_done(1);
        check("b2b_nwr", wr_a.size(), 32'd3);
        for (int i = 0; i < wr_a.size() && i < 3; i++) begin
            check($sformatf("b2b_addr%0d", i), wr_a[i], ea[i]);
            check($sformatf("b2b_data%0d", i), wr_d[i], ed[i]);
        end
        for (int i = 1; i < wr_c.size(); i++)
            check($sformatf("b2b_gap%0d", i), wr_c[i] - wr_c[i-1], 32'd2);
        check("b2b_idle_data", idle_bad, 32'd0);
        @(negedge clk);
        check("b2b_wcount", {16'd0, bus.write_count}, 32'd3);

        // Bad section, then restart from ERROR with an empty load
        sync();
        clear_log();
        pulse_start();
        send(32'd2);
        send(32'h0002_0001);
        @(negedge clk);
        check("bad_error",    {31'd0, bus.error},    32'd1);
        check("bad_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bad_busy",     {31'd0, bus.busy},     32'd0);
        check("bad_nwr",      wr_a.size(),           32'd0);
        pulse_start();
        @(negedge clk);
        check("restart_error", {31'd0, bus.error}, 32'd0);
        check("restart_busy",  {31'd0, bus.busy},  32'd1);
        sync();
        send(32'd0);
`ifdef CFG_SEQ_CHECKSUM_EN
        send(32'd0);
`endif
        wait_done(1);
        check("n0_nwr",    wr_a.size(), 32'd0);
        check("n0_wcount", {16'd0, bus.write_count}, 32'd0);

`ifdef CFG_SEQ_CHECKSUM_EN
        // Wrong trailer: writes stay issued, no done
        sync();
        clear_log();
        pulse_start();
        send(32'd2);
        send(32'h0004_0010);
        send(32'h0000_0001);
        send(32'h0007_0020);
        send(32'h0000_0002);
        send(32'h000B_0034);
        repeat (3) @(negedge clk);
        check("chk_error",  {31'd0, bus.error}, 32'd1);
        check("chk_nwr",    wr_a.size(),        32'd2);
        check("chk_done",   done_cnt,           32'd0);
        check("chk_wcount", {16'd0, bus.write_count}, 32'd2);
`endif

        // Reset in DATA with a data word pending
        sync();
        clear_log();
        pulse_start();
        send(32'd2);
        send(32'h0007_0001);
        send(32'h0000_0010);
        send(32'h0007_0002);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0099;
        reset        = 1'b1;
        sync();
        @(negedge clk);
        check("abort_addr",   bus.config_addr, 32'd0);
        check("abort_data",   bus.config_data, 32'd0);
        check("abort_wcount", {16'd0, bus.write_count}, 32'd0);
        check("abort_busy",   {31'd0, bus.busy}, 32'd0);
        sync();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_nwr",  wr_a.size(), 32'd1);
        check("abort_done", done_cnt,    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
